fifo_drain_control: RTL and testbench
=====================================

FIFO_DRAIN_CONTROL -- requirements
Module: fifo_drain_control

Interface
REQ-001 SHALL have parameter array_size, default 9: number of lane FIFOs drained.
REQ-002 SHALL have parameter dim_data_size, default 16: width of the dimension inputs.
REQ-003 SHALL have port clk  input  1: rising-edge clock.
REQ-004 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1: when low, the block freezes and forces read_enable to 0.
REQ-006 SHALL have port start  input  1: single-cycle request to begin a drain pass.
REQ-007 SHALL have port fifo_empty  input  array_size: per-lane FIFO empty flag.
REQ-008 SHALL have ports weight_size, image_height, image_width  input  dim_data_size each: kernel size K, image height H, image width W.
REQ-009 SHALL have port read_enable  output  array_size: combinational per-lane FIFO read strobe.
REQ-010 SHALL have port valid_out  output  array_size: read_enable delayed one cycle, marking FIFO data valid.
REQ-011 SHALL have ports busy, completed, error  output  1 each: registered status flags.

Function
REQ-012 SHALL implement the states IDLE, LOAD, STREAM and DONE.
REQ-013 In IDLE or DONE, start=1 SHALL latch K, H and W, clear error and completed, assert busy, and go to LOAD.
REQ-014 LOAD SHALL compute, in 32 bits, active=K*K and total=(H-K+1)*(W-K+1), and reset step counter t to 0.
REQ-015 LOAD SHALL go to DONE with error=1 if K=0, K>H, K>W or active>array_size; otherwise it SHALL go to STREAM.
REQ-016 Lane i SHALL be scheduled at step t when i<active and i<=t<i+total (diagonal skew of one step per lane).
REQ-017 stall SHALL be 1 when any scheduled lane has fifo_empty=1.
REQ-018 In STREAM, read_enable[i] SHALL equal scheduled(i,t) & !stall & enable; with no stall, the lanes therefore advance in lockstep.
REQ-019 t SHALL increment on each STREAM cycle where enable=1 and stall=0; a stall SHALL hold every lane, preserving the skew.
REQ-020 When t=active+total-2 is consumed without a stall, the block SHALL go to DONE.
REQ-021 On entering DONE, the block SHALL set completed=1 and busy=0, and hold both until the next start or reset.
REQ-022 Lanes at or above active SHALL never be read.
REQ-023 start while in LOAD or STREAM SHALL be ignored.
REQ-024 valid_out SHALL be a registered copy of read_enable, and SHALL also update while enable=0.
REQ-025 With enable=0, state, t and the flags SHALL hold and read_enable SHALL be 0.

Reset
REQ-026 Asserting reset (low) SHALL immediately force IDLE, t=0, busy=0, completed=0, error=0, valid_out=0 and read_enable=0, including mid-STREAM.
REQ-027 After reset is released, the block SHALL wait for a new start; no partial pass resumes.

Configuration
REQ-028 With macro DRAIN_STALL_CNT_EN defined, the block SHALL add output stall_count  32 bits: it clears on start, increments on each STREAM cycle with enable=1 and stall=1, and holds its value in DONE.
REQ-029 Without DRAIN_STALL_CNT_EN, the port and its counter SHALL be absent, with all other behaviour unchanged.

Verification
REQ-030 K=3, H=W=5, all FIFOs non-empty: read_enable[0] is high for steps 0-8 and read_enable[8] for steps 8-16; completed rises 17 STREAM cycles after STREAM entry; each lane reads exactly 9 times.
REQ-031 Same configuration with fifo_empty[4]=1 for 3 cycles at step 6: all read_enable are 0 for those 3 cycles, completion is delayed by 3 cycles, and stall_count=3 when DRAIN_STALL_CNT_EN is defined.
REQ-032 K=2, H=4, W=3, array_size=9: active=4 and total=6; lanes 4-8 never read; DONE is reached after 9 steps.
REQ-033 K=4 with array_size=9, or K=6 with H=5: error=1 and completed=1 two cycles after start, with no read_enable ever asserted.
REQ-034 reset pulsed low at step 5 of REQ-030: outputs are cleared immediately; a new start replays the full pass from step 0.
REQ-035 enable=0 for 4 cycles mid-STREAM, plus a start pulse during STREAM: read_enable is 0 during the gap, t holds, the start is ignored, and the total reads are unchanged.

Source files
------------

// File: rtl/fifo_drain_control.sv
// fifo_drain_control: diagonally skewed read scheduler for array_size lane FIFOs over a KxK window pass.
// Defining DRAIN_STALL_CNT_EN adds the 32-bit stall_count output.
module fifo_drain_control #(
  parameter int array_size    = 9,
  parameter int dim_data_size = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     start,
  input  logic [array_size-1:0]    fifo_empty,
  input  logic [dim_data_size-1:0] weight_size,
  input  logic [dim_data_size-1:0] image_height,
  input  logic [dim_data_size-1:0] image_width,
  output logic [array_size-1:0]    read_enable,
  output logic [array_size-1:0]    valid_out,
  output logic                     busy,
  output logic                     completed,
  output logic                     error
`ifdef DRAIN_STALL_CNT_EN
  ,
  output logic [31:0]              stall_count
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

  state_t                   state, state_next;
  logic [dim_data_size-1:0] k_q, h_q, w_q;
  logic [31:0]              active_q, total_q, t_q;
  logic [31:0]              k32, h32, w32, active_calc, total_calc;
  logic                     cfg_bad;
  logic [array_size-1:0]    scheduled;
  logic                     stall, last_step;
  logic                     go_start, do_load, load_err, t_advance, finish;

  assign k32         = 32'(k_q);
  assign h32         = 32'(h_q);
  assign w32         = 32'(w_q);
  assign active_calc = k32 * k32;
  assign total_calc  = (h32 - k32 + 32'd1) * (w32 - k32 + 32'd1);
  assign cfg_bad     = (k32 == 32'd0) || (k32 > h32) || (k32 > w32) ||
                       (active_calc > 32'(array_size));

  // Lane i is live for total consecutive steps starting at step i.
  always_comb begin
    scheduled = '0;
    for (int i = 0; i < array_size; i++) begin
      if ((32'(i) < active_q) && (t_q >= 32'(i)) && ((t_q - 32'(i)) < total_q))
        scheduled[i] = 1'b1;
    end
  end

  assign stall     = (state == STREAM) && |(scheduled & fifo_empty);
  assign last_step = (t_q == active_q + total_q - 32'd2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    read_enable = '0;
    go_start    = 1'b0;
    do_load     = 1'b0;
    load_err    = 1'b0;
    t_advance   = 1'b0;
    finish      = 1'b0;
    if (enable) begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            go_start   = 1'b1;
            state_next = LOAD;
          end
        end
        LOAD: begin
          do_load = 1'b1;
          if (cfg_bad) begin
            load_err   = 1'b1;
            state_next = DONE;
          end else begin
            state_next = STREAM;
          end
        end
        STREAM: begin
          if (!stall) begin
            read_enable = scheduled;
            t_advance   = 1'b1;
            if (last_step) begin
              finish     = 1'b1;
              state_next = DONE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath and status flags; everything except valid_out is frozen by the strobes when enable is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q         <= '0;
      h_q         <= '0;
      w_q         <= '0;
      active_q    <= '0;
      total_q     <= '0;
      t_q         <= '0;
      valid_out   <= '0;
      busy        <= 1'b0;
      completed   <= 1'b0;
      error       <= 1'b0;
`ifdef DRAIN_STALL_CNT_EN
      stall_count <= '0;
`endif
    end else begin
      valid_out <= read_enable;
      if (go_start) begin
        k_q       <= weight_size;
        h_q       <= image_height;
        w_q       <= image_width;
        error     <= 1'b0;
        completed <= 1'b0;
        busy      <= 1'b1;
`ifdef DRAIN_STALL_CNT_EN
        stall_count <= '0;
`endif
      end
      if (do_load) begin
        active_q <= active_calc;
        total_q  <= total_calc;
        t_q      <= '0;
      end
      if (load_err) begin
        error     <= 1'b1;
        completed <= 1'b1;
        busy      <= 1'b0;
      end
      if (t_advance) t_q <= t_q + 32'd1;
      if (finish) begin
        completed <= 1'b1;
        busy      <= 1'b0;
      end
`ifdef DRAIN_STALL_CNT_EN
      if (enable && stall) stall_count <= stall_count + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_drain_control.sv
// Self-checking bench for fifo_drain_control: a step-level model compared every cycle plus directed literal checks.
// Compiles with or without DRAIN_STALL_CNT_EN.
module tb_fifo_drain_control;

  localparam int AS = 9;
  localparam int DW = 16;
  localparam int P_IDLE = 0, P_LOAD = 1, P_STREAM = 2, P_DONE = 3;

  logic          clk, reset, enable, start;
  logic [AS-1:0] fifo_empty, read_enable, valid_out;
  logic [DW-1:0] weight_size, image_height, image_width;
  logic          busy, completed, error;
`ifdef DRAIN_STALL_CNT_EN
  logic [31:0]   stall_count;
`endif

  fifo_drain_control #(.array_size(AS), .dim_data_size(DW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .fifo_empty(fifo_empty), .weight_size(weight_size),
    .image_height(image_height), .image_width(image_width),
    .read_enable(read_enable), .valid_out(valid_out),
    .busy(busy), .completed(completed), .error(error)
`ifdef DRAIN_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: pass phase, step index and remaining-step count.
  int      m_phase;
  longint  m_k, m_h, m_w, m_act, m_tot, m_t, m_left, m_stalls;
  bit      m_busy, m_comp, m_err;
  logic [AS-1:0] m_valid;

  int lane_reads[AS];
  int snap_reads[AS];
  int re_cycles, busy_cycles, snap_re, snap_busy;

  function automatic void checkOutput(input string name, input logic [63:0] actual,
                                      input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endfunction

  function automatic logic [AS-1:0] schedule();
    logic [AS-1:0] sch;
    sch = '0;
    if (m_phase == P_STREAM)
      for (int i = 0; i < AS; i++)
        if (i < m_act && m_t >= i && m_t < i + m_tot) sch[i] = 1'b1;
    return sch;
  endfunction

  function automatic logic [AS-1:0] expRe();
    logic [AS-1:0] sch;
    sch = schedule();
    if (!enable || |(sch & fifo_empty)) return '0;
    return sch;
  endfunction

  task automatic modelReset();
    m_phase = P_IDLE; m_t = 0; m_left = 0; m_stalls = 0;
    m_busy = 0; m_comp = 0; m_err = 0; m_valid = '0;
    m_act = 0; m_tot = 0;
  endtask

  task automatic modelStep();
    logic [AS-1:0] sch;
    bit st;
    if (!reset) begin
      modelReset();
      return;
    end
    sch = schedule();
    st = |(sch & fifo_empty);
    m_valid = expRe();
    if (!enable) return;
    case (m_phase)
      P_IDLE, P_DONE: if (start) begin
        m_k = longint'(weight_size); m_h = longint'(image_height); m_w = longint'(image_width);
        m_err = 0; m_comp = 0; m_busy = 1; m_stalls = 0; m_phase = P_LOAD;
      end
      P_LOAD: begin
        m_act = m_k * m_k;
        if (m_k == 0 || m_k > m_h || m_k > m_w || m_act > AS) begin
          m_phase = P_DONE; m_err = 1; m_comp = 1; m_busy = 0;
        end else begin
          m_tot = (m_h - m_k + 1) * (m_w - m_k + 1);
          m_t = 0; m_left = m_act + m_tot - 1; m_phase = P_STREAM;
        end
      end
      P_STREAM: begin
        if (st) m_stalls++;
        else begin
          m_t++; m_left--;
          if (m_left == 0) begin m_phase = P_DONE; m_comp = 1; m_busy = 0; end
        end
      end
      default: ;
    endcase
  endtask

  task automatic compareAll();
    checkOutput("read_enable", 64'(read_enable), 64'(expRe()));
    checkOutput("valid_out",   64'(valid_out),   64'(m_valid));
    checkOutput("busy",        64'(busy),        64'(m_busy));
    checkOutput("completed",   64'(completed),   64'(m_comp));
    checkOutput("error",       64'(error),       64'(m_err));
`ifdef DRAIN_STALL_CNT_EN
    checkOutput("stall_count", 64'(stall_count), 64'(m_stalls));
`endif
    for (int i = 0; i < AS; i++) if (read_enable[i]) lane_reads[i]++;
    if (|read_enable) re_cycles++;
    if (busy) busy_cycles++;
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge, drive just after.
  task automatic tick();
    @(negedge clk);
    compareAll();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus(input int k, input int h, input int w);
    weight_size = DW'(k); image_height = DW'(h); image_width = DW'(w);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int n);
    n = 0;
    while (n < budget && completed !== 1'b1) begin
      tick();
      n++;
    end
    checkOutput("done_reached", 64'(completed), 64'(1));
  endtask

  task automatic snapshot();
    for (int i = 0; i < AS; i++) snap_reads[i] = lane_reads[i];
    snap_re = re_cycles;
    snap_busy = busy_cycles;
  endtask

  task automatic checkPass(input string tag, input int per_lane, input int n_active,
                           input int re_exp, input int busy_exp);
    for (int i = 0; i < AS; i++)
      checkOutput($sformatf("%s_lane%0d_reads", tag, i), 64'(lane_reads[i] - snap_reads[i]),
                  64'((i < n_active) ? per_lane : 0));
    checkOutput({tag, "_read_cycles"}, 64'(re_cycles - snap_re), 64'(re_exp));
    checkOutput({tag, "_busy_cycles"}, 64'(busy_cycles - snap_busy), 64'(busy_exp));
  endtask

  initial begin
    int n;
    for (int i = 0; i < AS; i++) lane_reads[i] = 0;
    re_cycles = 0; busy_cycles = 0;
    reset = 1'b1; enable = 1'b1; start = 1'b0; fifo_empty = '0;
    weight_size = '0; image_height = '0; image_width = '0;
    modelReset();
    #2 reset = 1'b0;
    modelReset();
    repeat (3) tick();
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_read_enable", 64'(read_enable), 64'(0));
    reset = 1'b1;
    repeat (2) tick();

    $display("[TB] K=3 H=5 W=5 clean pass");
    snapshot();
    applyStimulus(3, 5, 5);
    waitDone(60, n);
    checkOutput("k3_latency", 64'(n), 64'(18));
    checkOutput("k3_error", 64'(error), 64'(0));
    checkPass("k3", 9, 9, 17, 18);

    $display("[TB] K=3 H=5 W=5 with lane 4 empty at step 6");
    snapshot();
    applyStimulus(3, 5, 5);
    repeat (7) tick();
    fifo_empty[4] = 1'b1;
    #1 checkOutput("stall_read_enable", 64'(read_enable), 64'(0));
    repeat (3) tick();
    fifo_empty = '0;
    waitDone(60, n);
    checkOutput("stall_latency", 64'(10 + n), 64'(21));
    checkPass("stall", 9, 9, 17, 21);
`ifdef DRAIN_STALL_CNT_EN
    checkOutput("stall_count_lit", 64'(stall_count), 64'(3));
`endif

    $display("[TB] K=2 H=4 W=3 partial lane set");
    snapshot();
    applyStimulus(2, 4, 3);
    waitDone(60, n);
    checkOutput("k2_latency", 64'(n), 64'(10));
    checkPass("k2", 6, 4, 9, 10);

    $display("[TB] illegal configurations");
    snapshot();
    applyStimulus(4, 5, 5);
    waitDone(10, n);
    checkOutput("k4_latency", 64'(n), 64'(1));
    checkOutput("k4_error", 64'(error), 64'(1));
    checkOutput("k4_busy", 64'(busy), 64'(0));
    applyStimulus(6, 5, 8);
    waitDone(10, n);
    checkOutput("k6_latency", 64'(n), 64'(1));
    checkOutput("k6_error", 64'(error), 64'(1));
    applyStimulus(0, 5, 5);
    waitDone(10, n);
    checkOutput("k0_error", 64'(error), 64'(1));
    checkPass("illegal", 0, 0, 0, 3);

    $display("[TB] reset mid-stream then replay");
    applyStimulus(3, 5, 5);
    repeat (6) tick();
    checkOutput("step5_read_enable", 64'(read_enable), 64'(9'h03F));
    #1 reset = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_read_enable", 64'(read_enable), 64'(0));
    checkOutput("rst_valid_out", 64'(valid_out), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_completed", 64'(completed), 64'(0));
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    checkOutput("rst_idle_busy", 64'(busy), 64'(0));
    snapshot();
    applyStimulus(3, 5, 5);
    waitDone(60, n);
    checkOutput("replay_latency", 64'(n), 64'(18));
    checkPass("replay", 9, 9, 17, 18);

    $display("[TB] enable gap and ignored start");
    snapshot();
    applyStimulus(3, 5, 5);
    repeat (4) tick();
    checkOutput("step3_read_enable", 64'(read_enable), 64'(9'h00F));
    enable = 1'b0;
    #1 checkOutput("gap_read_enable", 64'(read_enable), 64'(0));
    repeat (4) tick();
    enable = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(60, n);
    checkOutput("gap_latency", 64'(9 + n), 64'(22));
    checkPass("gap", 9, 9, 17, 22);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
